mux_pipeline_scheduler: RTL and testbench

- Shares one mux_fixed_pipeline (PRIORITY=0) between INPUT_COUNT requesters.
- Each cycle, round-robin grants one pending requester. Its data enters the mux pipeline and emerges LATENCY cycles later, tagged with a valid flag and the requester index.
- Generates a per-level skewed select, so every pipeline level steers with the grant that belongs to the word it holds. This gives full one-word-per-cycle throughput.
- Sits between multiple producers and a single downstream consumer; there is no backpressure.

---
 rtl/mux_pipeline_pkg.sv | 58 +++++
 rtl/mux_fixed_pipeline.sv | 61 ++++++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/mux_pipeline_scheduler.sv | 84 ++++++++
 tb/tb_mux_pipeline_scheduler.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pipeline_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined mux scheduler.
package mux_pipeline_pkg;

  localparam int MAX_INPUT_COUNT = 64;
  localparam int MAX_SEL_W       = 6;

  // Width of a requester index / full mux select.
  function automatic int f_SelW(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // Select bits consumed by one mux level (1 for radix 2, 2 for radix 4).
  function automatic int f_GrpW(input int radix);
    return radix / 2;
  endfunction

  // Number of words alive after `level` mux levels (level 0 = raw inputs).
  function automatic int f_LevelCount(input int count, input int radix, input int level);
    int n;
    n = count;
    for (int l = 0; l < level; l++) n = (n + radix - 1) / radix;
    return n;
  endfunction

  // Levels needed to reduce `count` words to one; each level divides by radix, rounding up.
  function automatic int f_MuxLatency(input int count, input int radix);
    int n;
    int lat;
    n   = count;
    lat = 0;
    for (int l = 0; l < MAX_INPUT_COUNT; l++) begin
      if (n > 1 && radix > 1) begin
        n   = (n + radix - 1) / radix;
        lat = lat + 1;
      end
    end
    return lat;
  endfunction

  // Word offset of a level inside the flat register bus that holds levels 1..LATENCY.
  function automatic int f_LevelOffset(input int count, input int radix, input int level);
    int off;
    off = 0;
    for (int l = 1; l < level; l++) off = off + f_LevelCount(count, radix, l);
    return off;
  endfunction

  // Binary index of a one-hot (or zero) vector.
  function automatic logic [MAX_SEL_W-1:0] f_Onehot2Bin(input logic [MAX_INPUT_COUNT-1:0] onehot);
    logic [MAX_SEL_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < MAX_INPUT_COUNT; i++) begin
      if (onehot[i]) bin = bin | MAX_SEL_W'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/mux_fixed_pipeline.sv
// Tree of registered MUX_SIZE:1 muxes; level d steers with sel[d*GRP_W +: GRP_W].
module mux_fixed_pipeline
  import mux_pipeline_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int INPUT_COUNT = 10,
  parameter int MUX_SIZE    = 2,
  parameter int PRIORITY    = 0,
  parameter int GRP_W       = f_GrpW(MUX_SIZE),
  parameter int LATENCY     = f_MuxLatency(INPUT_COUNT, MUX_SIZE)
) (
  input  logic                         clk,
  input  logic [INPUT_COUNT*WIDTH-1:0] in,
  input  logic [LATENCY*GRP_W-1:0]     sel,
  output logic [WIDTH-1:0]             out
);

  localparam int RADIX      = 1 << GRP_W;
  localparam int STAGE_COLS = f_LevelOffset(INPUT_COUNT, MUX_SIZE, LATENCY + 1);
  localparam int LAST_OFF   = f_LevelOffset(INPUT_COUNT, MUX_SIZE, LATENCY);

  if (MUX_SIZE != 2 && MUX_SIZE != 4) begin : g_bad_radix
    $error("mux_fixed_pipeline: MUX_SIZE must be 2 or 4");
  end
  if (PRIORITY != 0) begin : g_bad_priority
    $error("mux_fixed_pipeline: only the index-select variant is implemented");
  end

  // Levels 1..LATENCY packed back to back; level 0 is the input bus itself.
  logic [STAGE_COLS*WIDTH-1:0] stage;

  for (genvar d = 0; d < LATENCY; d++) begin : g_lvl
    localparam int N_IN    = f_LevelCount(INPUT_COUNT, MUX_SIZE, d);
    localparam int N_OUT   = f_LevelCount(INPUT_COUNT, MUX_SIZE, d + 1);
    localparam int OFF_IN  = f_LevelOffset(INPUT_COUNT, MUX_SIZE, d);
    localparam int OFF_OUT = f_LevelOffset(INPUT_COUNT, MUX_SIZE, d + 1);

    for (genvar j = 0; j < N_OUT; j++) begin : g_col
      logic [WIDTH-1:0] cand [RADIX];

      for (genvar k = 0; k < RADIX; k++) begin : g_leg
        if (j * RADIX + k >= N_IN) begin : g_pad
          assign cand[k] = '0;
        end else if (d == 0) begin : g_from_in
          assign cand[k] = in[(j*RADIX + k)*WIDTH +: WIDTH];
        end else begin : g_from_stage
          assign cand[k] = stage[(OFF_IN + j*RADIX + k)*WIDTH +: WIDTH];
        end
      end

      // One mux leg per column, registered.
      always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; validity travels in the control pipe.
        stage[(OFF_OUT + j)*WIDTH +: WIDTH] <= cand[sel[d*GRP_W +: GRP_W]];
      end
    end
  end

  assign out = stage[LAST_OFF*WIDTH +: WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, rotating priority pointer.
module rr_arbiter
  import mux_pipeline_pkg::*;
#(
  parameter int INPUT_COUNT = 10,
  parameter int SEL_W       = f_SelW(INPUT_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_COUNT-1:0] req,
  output logic [INPUT_COUNT-1:0] grant,
  output logic [SEL_W-1:0]       gidx,
  output logic                   gvld
);

  localparam int IDX_W = SEL_W + 1;

  logic [SEL_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Scan from ptr upward with explicit wrap; first pending requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < INPUT_COUNT; k++) begin
      idx = {1'b0, ptr} + IDX_W'(k);
      if (idx >= IDX_W'(INPUT_COUNT)) idx = idx - IDX_W'(INPUT_COUNT);
      if (!found && req[idx[SEL_W-1:0]]) begin
        grant[idx[SEL_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
    if (rst) grant = '0;
  end

  assign gidx = SEL_W'(f_Onehot2Bin(MAX_INPUT_COUNT'(grant)));
  assign gvld = |grant;

  // Priority moves to the index just after the winner; holds when idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) begin
      ptr <= '0;
    end else if (gvld) begin
      ptr <= (gidx == SEL_W'(INPUT_COUNT - 1)) ? '0 : gidx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/mux_pipeline_scheduler.sv
// Round-robin scheduler feeding one shared pipelined mux with per-level skewed selects.
module mux_pipeline_scheduler
  import mux_pipeline_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int INPUT_COUNT = 10,
  parameter int MUX_SIZE    = 2,
  parameter int SEL_W       = f_SelW(INPUT_COUNT),
  parameter int GRP_W       = f_GrpW(MUX_SIZE),
  parameter int LATENCY     = f_MuxLatency(INPUT_COUNT, MUX_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUT_COUNT-1:0]       req,
  input  logic [INPUT_COUNT*WIDTH-1:0] in,
  output logic [INPUT_COUNT-1:0]       grant,
  output logic [WIDTH-1:0]             out,
  output logic                         out_valid,
  output logic [SEL_W-1:0]             out_id
);

  localparam int SR_W = LATENCY * SEL_W;

  logic [SEL_W-1:0]         gidx;
  logic                     gvld;
  logic [SR_W-1:0]          gidx_sr;
  logic [LATENCY-1:0]       gvld_sr;
  logic [LATENCY*GRP_W-1:0] sel;

  rr_arbiter #(
    .INPUT_COUNT (INPUT_COUNT),
    .SEL_W       (SEL_W)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .gidx  (gidx),
    .gvld  (gvld)
  );

  // Grant index/valid delay lines; slot k-1 holds the value from k cycles ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      gidx_sr <= '0;
      gvld_sr <= '0;
    end else begin
      gidx_sr <= SR_W'({gidx_sr, gidx});
      gvld_sr <= LATENCY'({gvld_sr, gvld});
    end
  end

  // Level d steers with the select digit of the word it currently holds.
  for (genvar d = 0; d < LATENCY; d++) begin : g_sel
    localparam int LO   = d * GRP_W;
    localparam int TAKE = (SEL_W - LO < GRP_W) ? SEL_W - LO : GRP_W;

    if (LO >= SEL_W) begin : g_zero
      assign sel[LO +: GRP_W] = '0;
    end else if (d == 0) begin : g_now
      assign sel[LO +: GRP_W] = GRP_W'(gidx[LO +: TAKE]);
    end else begin : g_delayed
      assign sel[LO +: GRP_W] = GRP_W'(gidx_sr[(d-1)*SEL_W + LO +: TAKE]);
    end
  end

  mux_fixed_pipeline #(
    .WIDTH       (WIDTH),
    .INPUT_COUNT (INPUT_COUNT),
    .MUX_SIZE    (MUX_SIZE),
    .PRIORITY    (0),
    .GRP_W       (GRP_W),
    .LATENCY     (LATENCY)
  ) u_mux (
    .clk (clk),
    .in  (in),
    .sel (sel),
    .out (out)
  );

  assign out_valid = gvld_sr[LATENCY-1];
  assign out_id    = gidx_sr[(LATENCY-1)*SEL_W +: SEL_W];

endmodule

// File: tb/tb_mux_pipeline_scheduler.sv
// Directed and randomized checks of the round-robin pipelined mux scheduler.
module tb_mux_pipeline_scheduler;

  localparam int WIDTH = 4;
  localparam int N     = 10;
  localparam int MUX   = 2;
  localparam int SEL_W = 4;
  localparam int LAT   = 4;
  localparam logic [N*WIDTH-1:0] RAMP = 40'h9876543210;

  typedef struct {
    logic             v;
    logic [SEL_W-1:0] id;
    logic [WIDTH-1:0] d;
  } sb_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       req = '0;
  logic [N*WIDTH-1:0] in  = RAMP;
  logic [N-1:0]       grant;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic [SEL_W-1:0]   out_id;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mux_pipeline_scheduler #(
    .WIDTH       (WIDTH),
    .INPUT_COUNT (N),
    .MUX_SIZE    (MUX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in        (in),
    .grant     (grant),
    .out       (out),
    .out_valid (out_valid),
    .out_id    (out_id)
  );

  // Advance to the next cycle and drive its inputs; returns with outputs settled.
  task automatic next_cycle(input logic [N-1:0] r, input logic rs, input logic [N*WIDTH-1:0] d);
    @(posedge clk);
    #2;
    req = r;
    rst = rs;
    in  = d;
    #1;
  endtask

  // Reset edge, then return in the first cycle after reset with req low.
  task automatic apply_reset();
    next_cycle('0, 1'b1, RAMP);
    next_cycle('0, 1'b0, RAMP);
  endtask

  task automatic test_reset();
    next_cycle('1, 1'b1, RAMP);
    n_checks++;
    if (grant !== '0) $display("FAIL reset_grant: got %h want 000", grant);
    else n_pass++;
    next_cycle('0, 1'b0, RAMP);
    n_checks++;
    if (out_valid !== 1'b0 || out_id !== '0)
      $display("FAIL reset_outputs: valid=%b id=%0d want valid=0 id=0", out_valid, out_id);
    else n_pass++;
    next_cycle('1, 1'b0, RAMP);
    n_checks++;
    if (grant !== 10'h001) $display("FAIL reset_first_grant: got %h want 001", grant);
    else n_pass++;
  endtask

  task automatic test_single_pulse();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      next_cycle('0, 1'b0, RAMP);
      n_checks++;
      if (grant !== '0 || out_valid !== 1'b0)
        $display("FAIL pulse_idle cyc %0d: grant=%h valid=%b want 000/0", k, grant, out_valid);
      else n_pass++;
    end
    next_cycle(10'h008, 1'b0, RAMP);
    n_checks++;
    if (grant !== 10'h008) $display("FAIL pulse_grant: got %h want 008", grant);
    else n_pass++;
    for (int k = 1; k <= 6; k++) begin
      next_cycle('0, 1'b0, RAMP);
      n_checks++;
      if (out_valid !== (k == LAT) || (k == LAT && (out !== 4'd3 || out_id !== 4'd3)))
        $display("FAIL pulse_out +%0d: valid=%b id=%0d out=%0d want valid=%b id=3 out=3",
                 k, out_valid, out_id, out, (k == LAT));
      else n_pass++;
    end
  endtask

  task automatic test_all_req();
    logic [N-1:0]     exp_g;
    logic             exp_v;
    logic [SEL_W-1:0] exp_id;
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      next_cycle((k < 12) ? '1 : '0, 1'b0, RAMP);
      exp_g  = (k < 12) ? (N'(1) << (k % 10)) : '0;
      exp_v  = (k >= LAT && k < 12 + LAT);
      exp_id = exp_v ? SEL_W'((k - LAT) % 10) : '0;
      n_checks++;
      if (grant !== exp_g) $display("FAIL all_req_grant cyc %0d: got %h want %h", k, grant, exp_g);
      else n_pass++;
      n_checks++;
      if (out_valid !== exp_v || (exp_v && (out_id !== exp_id || out !== WIDTH'(exp_id))))
        $display("FAIL all_req_out cyc %0d: valid=%b id=%0d out=%0d want valid=%b id=%0d",
                 k, out_valid, out_id, out, exp_v, exp_id);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0]     exp_g;
    logic             exp_v;
    logic [SEL_W-1:0] exp_id;
    apply_reset();
    for (int k = 0; k < 13; k++) begin
      next_cycle((k < 8) ? 10'h201 : 10'h000, 1'b0, RAMP);
      exp_g  = (k < 8) ? ((k % 2 == 0) ? 10'h001 : 10'h200) : 10'h000;
      exp_v  = (k >= LAT && k < 8 + LAT);
      exp_id = (exp_v && ((k - LAT) % 2 == 1)) ? 4'd9 : 4'd0;
      n_checks++;
      if (grant !== exp_g) $display("FAIL wrap_grant cyc %0d: got %h want %h", k, grant, exp_g);
      else n_pass++;
      n_checks++;
      if (out_valid !== exp_v || (exp_v && (out_id !== exp_id || out !== WIDTH'(exp_id))))
        $display("FAIL wrap_out cyc %0d: valid=%b id=%0d out=%0d want valid=%b id=%0d",
                 k, out_valid, out_id, out, exp_v, exp_id);
      else n_pass++;
    end
  endtask

  task automatic test_toggle();
    logic [N-1:0] r;
    logic         exp_v;
    apply_reset();
    for (int k = 0; k < 13; k++) begin
      r     = (k < 8 && k % 2 == 0) ? 10'h004 : 10'h000;
      next_cycle(r, 1'b0, RAMP);
      exp_v = (k >= LAT && k < 8 + LAT && k % 2 == 0);
      n_checks++;
      if (grant !== r) $display("FAIL toggle_grant cyc %0d: got %h want %h", k, grant, r);
      else n_pass++;
      n_checks++;
      if (out_valid !== exp_v || (exp_v && (out_id !== 4'd2 || out !== 4'd2)))
        $display("FAIL toggle_out cyc %0d: valid=%b id=%0d out=%0d want valid=%b id=2 out=2",
                 k, out_valid, out_id, out, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_single_held();
    logic exp_v;
    apply_reset();
    for (int k = 0; k < 11; k++) begin
      next_cycle((k < 6) ? 10'h020 : 10'h000, 1'b0, RAMP);
      exp_v = (k >= LAT && k < 6 + LAT);
      n_checks++;
      if (grant !== ((k < 6) ? 10'h020 : 10'h000))
        $display("FAIL held_grant cyc %0d: got %h", k, grant);
      else n_pass++;
      n_checks++;
      if (out_valid !== exp_v || (exp_v && (out_id !== 4'd5 || out !== 4'd5)))
        $display("FAIL held_out cyc %0d: valid=%b id=%0d out=%0d want valid=%b id=5 out=5",
                 k, out_valid, out_id, out, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    logic [N-1:0]     exp_g;
    logic             exp_v;
    logic [SEL_W-1:0] exp_id;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      next_cycle('1, 1'b0, RAMP);
      exp_g = N'(1) << k;
      n_checks++;
      if (grant !== exp_g) $display("FAIL mid_pre_grant cyc %0d: got %h want %h", k, grant, exp_g);
      else n_pass++;
    end
    next_cycle('1, 1'b1, RAMP);
    n_checks++;
    if (grant !== '0 || out_valid !== 1'b1 || out_id !== 4'd2)
      $display("FAIL mid_rst_cycle: grant=%h valid=%b id=%0d want 000/1/2", grant, out_valid, out_id);
    else n_pass++;
    for (int j = 0; j < 7; j++) begin
      next_cycle('1, 1'b0, RAMP);
      exp_g  = N'(1) << j;
      exp_v  = (j >= LAT);
      exp_id = exp_v ? SEL_W'(j - LAT) : '0;
      n_checks++;
      if (grant !== exp_g) $display("FAIL mid_post_grant cyc %0d: got %h want %h", j, grant, exp_g);
      else n_pass++;
      n_checks++;
      if (out_valid !== exp_v || (exp_v && (out_id !== exp_id || out !== WIDTH'(exp_id))))
        $display("FAIL mid_post_out cyc %0d: valid=%b id=%0d want valid=%b id=%0d",
                 j, out_valid, out_id, exp_v, exp_id);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    sb_t              q[$];
    sb_t              e;
    sb_t              ent;
    logic [N-1:0]     cur;
    logic [N-1:0]     exp_g;
    logic [N*WIDTH-1:0] d;
    logic [63:0]      rnd;
    int               ptr_m;
    int               g;
    int               idx;
    int               wait_cnt [N];
    int               max_wait;
    logic             found;
    apply_reset();
    for (int i = 0; i < LAT; i++) begin
      ent.v = 1'b0; ent.id = '0; ent.d = '0;
      q.push_back(ent);
    end
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    max_wait = 0;
    ptr_m    = 0;
    cur      = '0;
    for (int cyc = 0; cyc < 2000 + LAT; cyc++) begin
      if (cyc >= 2000) cur = '0;
      else if ($urandom_range(15) == 0) cur = '0;
      else cur = cur | (N'($urandom) & N'($urandom));
      rnd = {$urandom, $urandom};
      d   = rnd[N*WIDTH-1:0];
      next_cycle(cur, 1'b0, d);

      e = q.pop_front();
      n_checks++;
      if (e.v ? (out_valid !== 1'b1 || out_id !== e.id || out !== e.d) : (out_valid !== 1'b0))
        $display("FAIL rand_out cyc %0d: valid=%b id=%0d out=%h want valid=%b id=%0d out=%h",
                 cyc, out_valid, out_id, out, e.v, e.id, e.d);
      else n_pass++;

      exp_g = '0;
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (!found && cur[idx]) begin
          exp_g[idx] = 1'b1;
          found      = 1'b1;
          g          = idx;
        end
      end
      n_checks++;
      if (grant !== exp_g || !$onehot0(grant))
        $display("FAIL rand_grant cyc %0d: got %h want %h (req %h)", cyc, grant, exp_g, cur);
      else n_pass++;
      if (found) ptr_m = (g == N - 1) ? 0 : g + 1;

      ent.v  = found;
      ent.id = SEL_W'(g);
      ent.d  = d[g*WIDTH +: WIDTH];
      q.push_back(ent);

      for (int i = 0; i < N; i++) begin
        if (cur[i] && grant[i] !== 1'b1) wait_cnt[i] = wait_cnt[i] + 1;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      cur = cur & ~grant;
    end
    n_checks++;
    if (max_wait > 10) $display("FAIL rand_starvation: longest wait %0d cycles, limit 10", max_wait);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_all_req();
    test_wrap();
    test_toggle();
    test_single_held();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
